mc_control_fsm: RTL

- Multicycle MIPS main control unit that sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives the write-register destination select (RegDst) plus all other datapath enables and mux selects.
- Sits between the instruction register opcode field and the datapath.
- Stalls on a variable-latency memory through a ready handshake.

---
 rtl/mc_control_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// and stalls on a ready-handshaked memory, flagging a sticky timeout on long waits.
//
// state      | meaning
// S_RESET    | post-reset idle, all outputs low
// S_FETCH    | read instruction, PC <= PC+4 on mem_ready
// S_DECODE   | register read, branch target precompute
// S_MEMADR   | lw/sw address = A + signext(imm)
// S_MEMRD    | data memory read (waits on mem_ready)
// S_MEMWB    | rt <= MDR
// S_MEMWR    | data memory write (waits on mem_ready)
// S_EXEC     | R-type ALU operation
// S_ALUWB    | rd <= ALUOut
// S_BRANCH   | beq compare, conditional PC load
// S_ADDIEX   | A + signext(imm)
// S_ADDIWB   | rt <= ALUOut
// S_JUMP     | PC <= jump target
// S_JAL      | r31 <= PC, PC <= jump target
// S_ILLEGAL  | one-cycle illegal_op pulse
module mc_control_fsm #(
  parameter int STATE_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic               mem_ready,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic [1:0]         MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [STATE_W-1:0] {
    S_RESET   = STATE_W'(0),
    S_FETCH   = STATE_W'(1),
    S_DECODE  = STATE_W'(2),
    S_MEMADR  = STATE_W'(3),
    S_MEMRD   = STATE_W'(4),
    S_MEMWB   = STATE_W'(5),
    S_MEMWR   = STATE_W'(6),
    S_EXEC    = STATE_W'(7),
    S_ALUWB   = STATE_W'(8),
    S_BRANCH  = STATE_W'(9),
    S_ADDIEX  = STATE_W'(10),
    S_ADDIWB  = STATE_W'(11),
    S_JUMP    = STATE_W'(12),
    S_JAL     = STATE_W'(13),
    S_ILLEGAL = STATE_W'(14)
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       waiting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Opcode is re-sampled here; anything other than lw/sw is treated as illegal
      S_MEMADR: begin
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_ILLEGAL;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JAL, S_ILLEGAL:
                 state_d = S_FETCH;
      default:   state_d = S_RESET;
    endcase
  end

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready;

  // Counter saturates at TIMEOUT so the sticky flag cannot be undone by wrap-around
  always_comb begin
    cnt_d     = 8'd0;
    timeout_d = timeout_q;
    if (waiting && (state_d == state_q)) begin
      cnt_d = (cnt_q >= TMO) ? cnt_q : cnt_q + 8'd1;
      if (cnt_d >= TMO) timeout_d = 1'b1;
    end
  end

  always_comb begin
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 2'b01;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      // PC already holds PC+4 from fetch, so r31 gets the return address
      S_JAL: begin
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign mem_timeout = timeout_q;
  assign state       = STATE_W'(state_q);

endmodule
